// File: rtl/ddr_mon_pkg.sv
// Shared encodings and types for the DDR3 app-interface monitor.
package ddr_mon_pkg;

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   typedef enum logic [1:0] {
      StIdle      = 2'd0,
      StArmed     = 2'd1,
      StCapturing = 2'd2,
      StDone      = 2'd3
   } mon_state_e;

   // Layout of one capture entry at the default widths (TS_W=16, ADDR_W=28).
   typedef struct packed {
      logic [15:0] ts;
      logic [2:0]  cmd;
      logic [27:0] addr;
   } cap_entry_t;

endpackage

// File: rtl/ddr_mon_ts_fifo.sv
// Small synchronous FIFO for request timestamps; used only when DDR_MON_LATENCY_EN is defined.
module ddr_mon_ts_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 64,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;

   // Extra pointer bit separates full from empty when the indices match.
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign pop_data = mem[rd_ptr_q[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr_q[PTR_W-1:0]] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/ddr_app_monitor.sv
// Passive MIG app-interface monitor: statistics, outstanding reads and a triggered command trace.
// Define DDR_MON_LATENCY_EN to add read-latency outputs rd_lat_max / rd_lat_last.
module ddr_app_monitor
   import ddr_mon_pkg::*;
#(
   parameter int unsigned ADDR_W = 28,
   parameter int unsigned DATA_W = 512,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned OUTS_W = 6,
   parameter int unsigned TS_W   = 16,
   localparam int unsigned IDX_W   = $clog2(DEPTH),
   localparam int unsigned ENTRY_W = TS_W + 3 + ADDR_W
) (
   input  logic               ui_clk,
   input  logic               sys_rst,
   input  logic [ADDR_W-1:0]  app_addr,
   input  logic [2:0]         app_cmd,
   input  logic               app_en,
   input  logic               app_rdy,
   input  logic               app_wdf_wren,
   input  logic               app_wdf_end,
   input  logic               app_wdf_rdy,
   input  logic               app_rd_data_valid,
   input  logic               app_rd_data_end,
   input  logic               clr,
   input  logic               arm,
   input  logic [ADDR_W-1:0]  trig_addr,
   input  logic [ADDR_W-1:0]  trig_mask,
   input  logic [2:0]         trig_cmd,
   input  logic               trig_any,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic [ENTRY_W-1:0] rd_entry,
   output logic [1:0]         state,
   output logic [IDX_W:0]     cap_count,
   output logic [CNT_W-1:0]   rd_cmd_cnt,
   output logic [CNT_W-1:0]   wr_cmd_cnt,
   output logic [CNT_W-1:0]   wr_beat_cnt,
   output logic [CNT_W-1:0]   rd_beat_cnt,
   output logic [OUTS_W-1:0]  outstanding,
`ifdef DDR_MON_LATENCY_EN
   output logic [TS_W-1:0]    rd_lat_max,
   output logic [TS_W-1:0]    rd_lat_last,
`endif
   output logic               err_unexp_rd,
   output logic               err_ovf
);

   if ((DATA_W % 8) != 0 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
      $error("ddr_app_monitor: DATA_W must be a multiple of 8, DEPTH a power of two >= 4");
   end

   localparam logic [IDX_W:0] CapFull = DEPTH[IDX_W:0];

   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        cmd_q;
   logic              en_q, rdy_q, wren_q, wend_q, wrdy_q, rvalid_q, rend_q;
   logic [TS_W-1:0]   ts_q;

   always_ff @(posedge ui_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         addr_q   <= '0;
         cmd_q    <= '0;
         en_q     <= 1'b0;
         rdy_q    <= 1'b0;
         wren_q   <= 1'b0;
         wend_q   <= 1'b0;
         wrdy_q   <= 1'b0;
         rvalid_q <= 1'b0;
         rend_q   <= 1'b0;
      end else begin
         addr_q   <= app_addr;
         cmd_q    <= app_cmd;
         en_q     <= app_en;
         rdy_q    <= app_rdy;
         wren_q   <= app_wdf_wren;
         wend_q   <= app_wdf_end;
         wrdy_q   <= app_wdf_rdy;
         rvalid_q <= app_rd_data_valid;
         rend_q   <= app_rd_data_end;
      end
   end

   logic acc, acc_rd, acc_wr, wr_beat, rd_beat, ovf_ev, unexp_ev, trig_hit;

   assign acc      = en_q & rdy_q;
   assign acc_rd   = acc & (cmd_q == CMD_RD);
   assign acc_wr   = acc & (cmd_q == CMD_WR);
   assign wr_beat  = wren_q & wrdy_q;
   assign rd_beat  = rvalid_q;
   assign ovf_ev   = acc_rd & ~rd_beat & (outstanding == '1);
   assign unexp_ev = rd_beat & ~acc_rd & (outstanding == '0);
   assign trig_hit = ((addr_q & trig_mask) == (trig_addr & trig_mask)) &&
                     (trig_any || (cmd_q == trig_cmd));

   // Statistics, timestamp and sticky errors; clr takes priority over any event.
   always_ff @(posedge ui_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         ts_q         <= '0;
         rd_cmd_cnt   <= '0;
         wr_cmd_cnt   <= '0;
         wr_beat_cnt  <= '0;
         rd_beat_cnt  <= '0;
         err_unexp_rd <= 1'b0;
         err_ovf      <= 1'b0;
      end else if (clr) begin
         ts_q         <= '0;
         rd_cmd_cnt   <= '0;
         wr_cmd_cnt   <= '0;
         wr_beat_cnt  <= '0;
         rd_beat_cnt  <= '0;
         err_unexp_rd <= 1'b0;
         err_ovf      <= 1'b0;
      end else begin
         ts_q <= ts_q + 1'b1;
         if (acc_rd && rd_cmd_cnt != '1)   rd_cmd_cnt  <= rd_cmd_cnt + 1'b1;
         if (acc_wr && wr_cmd_cnt != '1)   wr_cmd_cnt  <= wr_cmd_cnt + 1'b1;
         if (wr_beat && wr_beat_cnt != '1) wr_beat_cnt <= wr_beat_cnt + 1'b1;
         if (rd_beat && rd_beat_cnt != '1) rd_beat_cnt <= rd_beat_cnt + 1'b1;
         if (unexp_ev) err_unexp_rd <= 1'b1;
         if (ovf_ev)   err_ovf      <= 1'b1;
      end
   end

   // Tracks bus state rather than statistics, so clr leaves it alone.
   always_ff @(posedge ui_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         outstanding <= '0;
      end else if (acc_rd && !rd_beat && outstanding != '1) begin
         outstanding <= outstanding + 1'b1;
      end else if (rd_beat && !acc_rd && outstanding != '0) begin
         outstanding <= outstanding - 1'b1;
      end
   end

   mon_state_e       state_q, state_d;
   logic [IDX_W:0]   cap_d;
   logic             buf_wr;
   logic [ENTRY_W-1:0] buf_mem [DEPTH];

   always_comb begin
      state_d = state_q;
      cap_d   = cap_count;
      buf_wr  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (arm) state_d = StArmed;
         end
         StArmed: begin
            if (acc && trig_hit) begin
               buf_wr  = 1'b1;
               cap_d   = cap_count + 1'b1;
               state_d = StCapturing;
            end
         end
         StCapturing: begin
            if (acc) begin
               buf_wr = 1'b1;
               cap_d  = cap_count + 1'b1;
               if (cap_d == CapFull) state_d = StDone;
            end
         end
         StDone: begin
            if (arm) begin
               state_d = StArmed;
               cap_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge ui_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q   <= StIdle;
         cap_count <= '0;
      end else begin
         state_q   <= state_d;
         cap_count <= cap_d;
      end
   end

   assign state = state_q;

   always_ff @(posedge ui_clk) begin
      if (buf_wr) buf_mem[cap_count[IDX_W-1:0]] <= {ts_q, cmd_q, addr_q};
   end

   always_ff @(posedge ui_clk or negedge sys_rst) begin
      if (!sys_rst) rd_entry <= '0;
      else          rd_entry <= buf_mem[rd_idx];
   end

   logic unused_wend;
   assign unused_wend = wend_q;

`ifdef DDR_MON_LATENCY_EN
   logic [TS_W-1:0] lat_head, lat_now;
   logic            fifo_full, fifo_empty, lat_push, lat_pop;

   assign lat_push = acc_rd & ~fifo_full;
   assign lat_pop  = rd_beat & rend_q & ~fifo_empty;
   assign lat_now  = ts_q - lat_head;

   ddr_mon_ts_fifo #(
      .WIDTH (TS_W),
      .DEPTH (1 << OUTS_W)
   ) u_ts_fifo (
      .clk       (ui_clk),
      .rst_n     (sys_rst),
      .push      (lat_push),
      .push_data (ts_q),
      .pop       (lat_pop),
      .pop_data  (lat_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge ui_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         rd_lat_max  <= '0;
         rd_lat_last <= '0;
      end else if (clr) begin
         rd_lat_max  <= '0;
         rd_lat_last <= '0;
      end else if (lat_pop) begin
         rd_lat_last <= lat_now;
         if (lat_now > rd_lat_max) rd_lat_max <= lat_now;
      end
   end
`else
   logic unused_rend;
   assign unused_rend = rend_q;
`endif

endmodule

// File: tb/tb_ddr_app_monitor.sv
// Directed self-checking bench for ddr_app_monitor (DEPTH=4, OUTS_W=2).
module tb_ddr_app_monitor;
   import ddr_mon_pkg::*;

   localparam int unsigned ADDR_W = 28;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned OUTS_W = 2;
   localparam int unsigned TS_W   = 16;

   logic              ui_clk = 1'b0;
   logic              sys_rst;
   logic [ADDR_W-1:0] app_addr, trig_addr, trig_mask;
   logic [2:0]        app_cmd, trig_cmd;
   logic              app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic              app_rd_data_valid, app_rd_data_end, clr, arm, trig_any;
   logic [1:0]        rd_idx;
   logic [TS_W+3+ADDR_W-1:0] rd_entry;
   logic [1:0]        state;
   logic [2:0]        cap_count;
   logic [CNT_W-1:0]  rd_cmd_cnt, wr_cmd_cnt, wr_beat_cnt, rd_beat_cnt;
   logic [OUTS_W-1:0] outstanding;
   logic              err_unexp_rd, err_ovf;
`ifdef DDR_MON_LATENCY_EN
   logic [TS_W-1:0]   rd_lat_max, rd_lat_last;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   cap_entry_t e0, e1;
   logic [15:0] ts_diff;

   always #5 ui_clk = ~ui_clk;

   ddr_app_monitor #(
      .ADDR_W (ADDR_W),
      .DATA_W (64),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W),
      .OUTS_W (OUTS_W),
      .TS_W   (TS_W)
   ) dut (
      .ui_clk            (ui_clk),
      .sys_rst           (sys_rst),
      .app_addr          (app_addr),
      .app_cmd           (app_cmd),
      .app_en            (app_en),
      .app_rdy           (app_rdy),
      .app_wdf_wren      (app_wdf_wren),
      .app_wdf_end       (app_wdf_end),
      .app_wdf_rdy       (app_wdf_rdy),
      .app_rd_data_valid (app_rd_data_valid),
      .app_rd_data_end   (app_rd_data_end),
      .clr               (clr),
      .arm               (arm),
      .trig_addr         (trig_addr),
      .trig_mask         (trig_mask),
      .trig_cmd          (trig_cmd),
      .trig_any          (trig_any),
      .rd_idx            (rd_idx),
      .rd_entry          (rd_entry),
      .state             (state),
      .cap_count         (cap_count),
      .rd_cmd_cnt        (rd_cmd_cnt),
      .wr_cmd_cnt        (wr_cmd_cnt),
      .wr_beat_cnt       (wr_beat_cnt),
      .rd_beat_cnt       (rd_beat_cnt),
      .outstanding       (outstanding),
`ifdef DDR_MON_LATENCY_EN
      .rd_lat_max        (rd_lat_max),
      .rd_lat_last       (rd_lat_last),
`endif
      .err_unexp_rd      (err_unexp_rd),
      .err_ovf           (err_ovf)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge ui_clk);
      #1;
   endtask

   task automatic issue(input logic [ADDR_W-1:0] a, input logic [2:0] c, input logic wbeat);
      app_en = 1'b1; app_rdy = 1'b1; app_addr = a; app_cmd = c;
      app_wdf_wren = wbeat; app_wdf_rdy = wbeat; app_wdf_end = wbeat;
      tick();
      app_en = 1'b0; app_rdy = 1'b0; app_wdf_wren = 1'b0; app_wdf_rdy = 1'b0; app_wdf_end = 1'b0;
   endtask

   task automatic beat();
      app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
      tick();
      app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic read_entry(input logic [1:0] idx, output cap_entry_t e);
      rd_idx = idx;
      tick();
      e = rd_entry;
   endtask

   initial begin
      sys_rst = 1'b1;
      app_addr = '0; app_cmd = '0; app_en = 0; app_rdy = 0; app_wdf_wren = 0; app_wdf_end = 0;
      app_wdf_rdy = 0; app_rd_data_valid = 0; app_rd_data_end = 0; clr = 0; arm = 0;
      trig_addr = '0; trig_mask = '0; trig_cmd = '0; trig_any = 0; rd_idx = '0;
      #1 sys_rst = 1'b0;
      #3;
      check("rst_rd_entry", rd_entry, 0);
      check("rst_state", state, 0);
      tick(2);
      sys_rst = 1'b1;
      tick(100);
      check("idle_state", state, 0);
      check("idle_cap_count", cap_count, 0);
      check("idle_counters", {rd_cmd_cnt, wr_cmd_cnt} | {wr_beat_cnt, rd_beat_cnt}, 0);
      check("idle_outstanding", outstanding, 0);
      check("idle_errors", {err_unexp_rd, err_ovf}, 0);

      // 5 writes with one data beat each, then 3 reads and their data
      for (int i = 0; i < 5; i++) issue(28'(i * 64), CMD_WR, 1'b1);
      for (int i = 0; i < 3; i++) issue(28'(i * 64), CMD_RD, 1'b0);
      tick(2);
      check("outs_after_reads", outstanding, 3);
      check("wr_cmd_cnt", wr_cmd_cnt, 5);
      check("wr_beat_cnt", wr_beat_cnt, 5);
      check("rd_cmd_cnt", rd_cmd_cnt, 3);
      for (int i = 0; i < 3; i++) beat();
      tick(2);
      check("rd_beat_cnt", rd_beat_cnt, 3);
      check("outs_drained", outstanding, 0);
      check("no_errors", {err_unexp_rd, err_ovf}, 0);

      // read data with nothing outstanding
      beat();
      tick(2);
      check("err_unexp_rd", err_unexp_rd, 1);
      check("outs_stays_0", outstanding, 0);
      // simultaneous accept and return at outstanding=2
      issue(28'h10, CMD_RD, 1'b0);
      issue(28'h20, CMD_RD, 1'b0);
      app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
      issue(28'h30, CMD_RD, 1'b0);
      app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
      tick(2);
      check("outs_net_zero", outstanding, 2);
      check("rd_cmd_cnt_6", rd_cmd_cnt, 6);
      check("rd_beat_cnt_5", rd_beat_cnt, 5);
      // saturate at 3 and overflow
      issue(28'h40, CMD_RD, 1'b0);
      issue(28'h50, CMD_RD, 1'b0);
      tick(2);
      check("outs_max", outstanding, 3);
      check("err_ovf", err_ovf, 1);
      check("rd_cmd_cnt_8", rd_cmd_cnt, 8);
      for (int i = 0; i < 4; i++) beat();
      tick(2);
      check("outs_after_drain", outstanding, 0);

      // write lands in stage 0 the same cycle clr is applied: clr wins
      issue(28'h60, CMD_WR, 1'b1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick(2);
      check("clr_wr_cmd", wr_cmd_cnt, 0);
      check("clr_wr_beat", wr_beat_cnt, 0);
      check("clr_rd_counts", {rd_cmd_cnt, rd_beat_cnt}, 0);
      check("clr_errors", {err_unexp_rd, err_ovf}, 0);

      // trigger: first a command-type mismatch, then trig_any
      pulse_arm();
      check("armed", state, 1);
      trig_addr = 28'h100; trig_mask = 28'hFFFFFFF; trig_cmd = CMD_RD; trig_any = 1'b0;
      issue(28'h100, CMD_WR, 1'b0);
      tick(2);
      check("no_trig_cmd_mismatch", state, 1);
      pulse_arm();
      check("arm_in_armed", state, 1);
      trig_any = 1'b1;
      issue(28'h0C0, CMD_WR, 1'b0);
      issue(28'h100, CMD_WR, 1'b0);
      issue(28'h140, CMD_RD, 1'b0);
      tick(2);
      check("capturing", state, 2);
      check("cap_count_2", cap_count, 2);
      read_entry(2'd0, e0);
      read_entry(2'd1, e1);
      check("entry0_addr", e0.addr, 28'h100);
      check("entry1_addr", e1.addr, 28'h140);
      check("entry1_cmd", e1.cmd, CMD_RD);
      ts_diff = e1.ts - e0.ts;
      check("entry_ts_step", ts_diff, 1);
      pulse_arm();
      tick();
      check("arm_in_capturing", state, 2);
      for (int i = 0; i < 4; i++) issue(28'h180 + 28'(i * 64), CMD_WR, 1'b0);
      tick(2);
      check("done", state, 3);
      check("cap_count_full", cap_count, 4);
      read_entry(2'd0, e0);
      read_entry(2'd1, e1);
      check("entry0_kept", e0.addr, 28'h100);
      check("entry1_kept", e1.addr, 28'h140);
      read_entry(2'd3, e1);
      check("entry3_addr", e1.addr, 28'h1C0);
      pulse_arm();
      check("rearmed", state, 1);
      check("rearm_cap_count", cap_count, 0);

      // asynchronous reset in the middle of a capture
      issue(28'h100, CMD_WR, 1'b0);
      issue(28'h200, CMD_WR, 1'b0);
      tick(2);
      check("capture_before_rst", state, 2);
      sys_rst = 1'b0;
      #1;
      check("midrst_state", state, 0);
      check("midrst_cap_count", cap_count, 0);
      check("midrst_outstanding", outstanding, 0);
      tick();
      sys_rst = 1'b1;
      tick(2);

`ifdef DDR_MON_LATENCY_EN
      issue(28'h300, CMD_RD, 1'b0);
      tick(21);
      beat();
      tick(2);
      check("lat_last_22", rd_lat_last, 22);
      check("lat_max_22", rd_lat_max, 22);
      issue(28'h340, CMD_RD, 1'b0);
      tick(4);
      beat();
      tick(2);
      check("lat_last_5", rd_lat_last, 5);
      check("lat_max_holds", rd_lat_max, 22);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("lat_clr", {rd_lat_max, rd_lat_last}, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
